// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multi-cycle sequencer for the RV32I core. It steps the shared
//            datapath through FETCH, DECODE, EXECUTE, MEM and WB for one
//            instruction at a time. It drives the instruction-memory and
//            data-memory request handshakes and gates the decoder's write
//            enables so each one takes effect in exactly one cycle per
//            instruction. It also detects halt (SYSTEM) and illegal opcodes,
//            and counts retired instructions.
//
// Ports    : clock        system clock, rising edge
//            reset        asynchronous, active-high
//            start        leaves IDLE (sampled only in IDLE)
//            opcode       instruction[6:0] of the latched instruction
//            dec_wEn      decoder register-write request
//            dec_mem_wEn  decoder store request
//            imem_req     instruction fetch request (FETCH)
//            imem_ready   instruction data valid
//            dmem_req     data memory request (MEM)
//            dmem_we      data memory write qualifier (MEM only)
//            dmem_ready   data access complete
//            ir_load      latch instruction register (FETCH & imem_ready)
//            pc_wEn       PC update enable (WB)
//            rf_wEn       qualified register-file write enable (WB only)
//            halted       in HALT
//            trap         in TRAP
//            trap_cause   00 none, 01 illegal opcode, 10 memory timeout
//            state        current state encoding
//            retired      retired-instruction count (wraps)
//
// Options  : MEM_TIMEOUT_EN  when defined, adds a wait watchdog on FETCH and
//                            MEM. After TIMEOUT_CYCLES consecutive not-ready
//                            cycles the controller enters TRAP with cause 10.
//                            When undefined, FETCH and MEM wait indefinitely.
//
// Revision : 1.0  initial release
// ============================================================================
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic        dec_wEn,
    input  logic        dec_mem_wEn,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_load,
    output logic        pc_wEn,
    output logic        rf_wEn,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    // ------------------------------------------------------------------
    // State encoding. The values are visible on the state port.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6,
        S_TRAP    = 3'd7
    } state_t;

    // RV32I major opcodes
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] c_CAUSE_NONE    = 2'b00;
    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;

    // The watchdog fires on the not-ready cycle that would be the
    // TIMEOUT_CYCLES-th one. The count holds the number of earlier
    // not-ready cycles, so the comparison is against the limit minus one.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  w_trap_cause_next;
    logic [1:0]  r_trap_cause;
    logic [31:0] r_retired;

    logic        w_op_valid;
    logic        w_op_mem;
    logic        w_op_system;
    logic        w_wait_expired;

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    always_comb begin
        w_op_valid = 1'b0;
        case (opcode)
            c_OP_OP, c_OP_OP_IMM, c_OP_LOAD, c_OP_STORE, c_OP_BRANCH,
            c_OP_JALR, c_OP_JAL, c_OP_AUIPC, c_OP_LUI: w_op_valid = 1'b1;
            default:                                   w_op_valid = 1'b0;
        endcase
    end

    assign w_op_mem    = (opcode == c_OP_LOAD) || (opcode == c_OP_STORE);
    assign w_op_system = (opcode == c_OP_SYSTEM);

    // ------------------------------------------------------------------
    // Memory wait watchdog
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       w_enter_wait_state;
    logic       w_waiting;

    // A self-loop in FETCH or MEM is not an entry, so the count keeps
    // running across consecutive wait cycles.
    assign w_enter_wait_state = (w_next_state != r_state) &&
                                ((w_next_state == S_FETCH) || (w_next_state == S_MEM));
    assign w_waiting          = ((r_state == S_FETCH) && !imem_ready) ||
                                ((r_state == S_MEM)   && !dmem_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
        end else if (w_enter_wait_state) begin
            r_wait_cnt <= 8'd0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_wait_expired = (r_wait_cnt >= c_TIMEOUT_LAST);
`else
    logic w_unused_timeout;

    assign w_wait_expired   = 1'b0;
    assign w_unused_timeout = ^{1'b0, c_TIMEOUT_LAST};
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A ready response takes priority over the
    // watchdog, so an access completing on the limit cycle never traps.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state      = r_state;
        w_trap_cause_next = c_CAUSE_NONE;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    w_next_state = S_DECODE;
                end else if (w_wait_expired) begin
                    w_next_state      = S_TRAP;
                    w_trap_cause_next = c_CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (w_op_system) begin
                    w_next_state = S_HALT;
                end else if (w_op_valid) begin
                    w_next_state = S_EXECUTE;
                end else begin
                    w_next_state      = S_TRAP;
                    w_trap_cause_next = c_CAUSE_ILLEGAL;
                end
            end
            S_EXECUTE: begin
                w_next_state = w_op_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    w_next_state = S_WB;
                end else if (w_wait_expired) begin
                    w_next_state      = S_TRAP;
                    w_trap_cause_next = c_CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Retired counter and trap cause. The cause is captured only on the
    // transition into TRAP and then holds until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired    <= 32'd0;
            r_trap_cause <= c_CAUSE_NONE;
        end else begin
            if (r_state == S_WB) begin
                r_retired <= r_retired + 32'd1;
            end
            if ((w_next_state == S_TRAP) && (r_state != S_TRAP)) begin
                r_trap_cause <= w_trap_cause_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. All are decoded from the registered state except ir_load,
    // which must capture the instruction in the same cycle memory
    // presents it.
    // ------------------------------------------------------------------
    assign imem_req   = (r_state == S_FETCH);
    assign ir_load    = (r_state == S_FETCH) && imem_ready;
    assign dmem_req   = (r_state == S_MEM);
    assign dmem_we    = (r_state == S_MEM) && dec_mem_wEn;
    assign pc_wEn     = (r_state == S_WB);
    assign rf_wEn     = (r_state == S_WB) && dec_wEn;
    assign halted     = (r_state == S_HALT);
    assign trap       = (r_state == S_TRAP);
    assign trap_cause = r_trap_cause;
    assign state      = r_state;
    assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Self-checking bench for multicycle_controller. Each test queues
//            per-cycle stimulus together with the expected output vector.
//            The queue is then played back one entry per clock: inputs are
//            driven just after the rising edge, and outputs are compared on
//            the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int TIMEOUT = 16;

    // Flag groups: {imem_req, ir_load, dmem_req, dmem_we, pc_wEn, rf_wEn, halted, trap}
    localparam logic [7:0] F_NONE   = 8'b0000_0000;
    localparam logic [7:0] F_FETCH  = 8'b1000_0000;
    localparam logic [7:0] F_IRLOAD = 8'b1100_0000;
    localparam logic [7:0] F_MEM_RD = 8'b0010_0000;
    localparam logic [7:0] F_MEM_WR = 8'b0011_0000;
    localparam logic [7:0] F_WB     = 8'b0000_1000;
    localparam logic [7:0] F_WB_RF  = 8'b0000_1100;
    localparam logic [7:0] F_HALT   = 8'b0000_0010;
    localparam logic [7:0] F_TRAP   = 8'b0000_0001;

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_BAD   = 7'b0000000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, imem_ready, dmem_ready, dec_wEn, dec_mem_wEn;
    logic [6:0]  opcode;
    logic        imem_req, dmem_req, dmem_we, ir_load, pc_wEn, rf_wEn, halted, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] retired;
    logic [12:0] obs;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        start;
        logic        imem_ready;
        logic        dmem_ready;
        logic        dec_wEn;
        logic        dec_mem_wEn;
        logic [6:0]  opcode;
        logic [12:0] exp;
    } cyc_t;

    cyc_t q[$];

    multicycle_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .dec_wEn     (dec_wEn),
        .dec_mem_wEn (dec_mem_wEn),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .ir_load     (ir_load),
        .pc_wEn      (pc_wEn),
        .rf_wEn      (rf_wEn),
        .halted      (halted),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .state       (state),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    assign obs = {state, imem_req, ir_load, dmem_req, dmem_we, pc_wEn, rf_wEn,
                  halted, trap, trap_cause};

    function automatic logic [12:0] ev(input logic [2:0] st, input logic [7:0] f,
                                       input logic [1:0] tc);
        return {st, f, tc};
    endfunction

    task automatic push(input logic st, input logic ir, input logic dr, input logic we,
                        input logic mwe, input logic [6:0] op, input logic [12:0] e);
        cyc_t c;
        c.start = st; c.imem_ready = ir; c.dmem_ready = dr;
        c.dec_wEn = we; c.dec_mem_wEn = mwe; c.opcode = op; c.exp = e;
        q.push_back(c);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        dec_wEn = 1'b0; dec_mem_wEn = 1'b0; opcode = OP_ALU;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Asynchronous reset: outputs clear without waiting for a clock edge.
    task automatic test_reset();
        int n = 0;
        cyc_t c;
        #1;
        checks++;
        if (obs !== ev(3'd0, F_NONE, 2'b00) || retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_initial: got %h/%0d want %h/0", obs, retired, ev(3'd0, F_NONE, 2'b00));
        end
        @(posedge clock); #1; reset = 1'b0;
        push(1, 0, 0, 0, 0, OP_ALU, ev(3'd0, F_NONE, 2'b00));
        push(0, 0, 0, 0, 0, OP_ALU, ev(3'd1, F_FETCH, 2'b00));
        push(0, 0, 0, 0, 0, OP_ALU, ev(3'd1, F_FETCH, 2'b00));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
        #2; reset = 1'b1; #1;
        checks++;
        if (obs !== ev(3'd0, F_NONE, 2'b00)) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs, ev(3'd0, F_NONE, 2'b00));
        end
        @(posedge clock); #1; reset = 1'b0;
    endtask

    // Zero-wait R-type: FETCH, DECODE, EXECUTE, WB. The store request is held
    // high throughout and must never appear on dmem_we.
    task automatic test_alu();
        int n = 0;
        cyc_t c;
        do_reset();
        push(1, 1, 1, 1, 1, OP_ALU, ev(3'd0, F_NONE, 2'b00));
        push(0, 1, 1, 1, 1, OP_ALU, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 1, 1, 1, 1, OP_ALU, ev(3'd2, F_NONE, 2'b00));
        push(0, 1, 1, 1, 1, OP_ALU, ev(3'd3, F_NONE, 2'b00));
        push(0, 1, 1, 1, 1, OP_ALU, ev(3'd5, F_WB_RF, 2'b00));
        push(0, 1, 1, 1, 1, OP_ALU, ev(3'd1, F_IRLOAD, 2'b00));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL alu cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
        checks++;
        if (retired !== 32'd1) begin
            errors++;
            $display("FAIL alu_retired: got %0d want 1", retired);
        end
    endtask

    // Zero-wait load: one MEM cycle, read only.
    task automatic test_load();
        int n = 0;
        cyc_t c;
        do_reset();
        push(1, 1, 1, 1, 0, OP_LOAD, ev(3'd0, F_NONE, 2'b00));
        push(0, 1, 1, 1, 0, OP_LOAD, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 1, 1, 1, 0, OP_LOAD, ev(3'd2, F_NONE, 2'b00));
        push(0, 1, 1, 1, 0, OP_LOAD, ev(3'd3, F_NONE, 2'b00));
        push(0, 1, 1, 1, 0, OP_LOAD, ev(3'd4, F_MEM_RD, 2'b00));
        push(0, 1, 1, 1, 0, OP_LOAD, ev(3'd5, F_WB_RF, 2'b00));
        push(0, 1, 1, 1, 0, OP_LOAD, ev(3'd1, F_IRLOAD, 2'b00));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL load cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
    endtask

    // Store with three wait cycles: MEM lasts four cycles with dmem_we high.
    // rf_wEn must stay low during MEM even though dec_wEn is high; the
    // decoder drops dec_wEn in WB as a store would.
    task automatic test_store_wait();
        int n = 0;
        cyc_t c;
        do_reset();
        push(1, 1, 0, 1, 1, OP_STORE, ev(3'd0, F_NONE, 2'b00));
        push(0, 1, 0, 1, 1, OP_STORE, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 1, 0, 1, 1, OP_STORE, ev(3'd2, F_NONE, 2'b00));
        push(0, 1, 0, 1, 1, OP_STORE, ev(3'd3, F_NONE, 2'b00));
        for (int i = 0; i < 3; i++)
            push(0, 1, 0, 1, 1, OP_STORE, ev(3'd4, F_MEM_WR, 2'b00));
        push(0, 1, 1, 1, 1, OP_STORE, ev(3'd4, F_MEM_WR, 2'b00));
        push(0, 1, 1, 0, 1, OP_STORE, ev(3'd5, F_WB, 2'b00));
        push(0, 0, 1, 0, 1, OP_STORE, ev(3'd1, F_FETCH, 2'b00));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL store cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
        checks++;
        if (retired !== 32'd1) begin
            errors++;
            $display("FAIL store_retired: got %0d want 1", retired);
        end
    endtask

    // Two instructions back to back; the second fetch waits one cycle.
    task automatic test_back_to_back();
        int n = 0;
        cyc_t c;
        do_reset();
        push(1, 1, 1, 1, 0, OP_ALU, ev(3'd0, F_NONE, 2'b00));
        push(0, 1, 1, 1, 0, OP_ALU, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 1, 1, 1, 0, OP_ALU, ev(3'd2, F_NONE, 2'b00));
        push(0, 1, 1, 1, 0, OP_ALU, ev(3'd3, F_NONE, 2'b00));
        push(0, 0, 1, 1, 0, OP_ALU, ev(3'd5, F_WB_RF, 2'b00));
        push(0, 0, 1, 1, 0, OP_ALU, ev(3'd1, F_FETCH, 2'b00));
        push(0, 1, 1, 0, 0, OP_IMM, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 1, 1, 0, 0, OP_IMM, ev(3'd2, F_NONE, 2'b00));
        push(0, 1, 1, 0, 0, OP_IMM, ev(3'd3, F_NONE, 2'b00));
        push(0, 0, 1, 0, 0, OP_IMM, ev(3'd5, F_WB, 2'b00));
        push(0, 0, 1, 0, 0, OP_IMM, ev(3'd1, F_FETCH, 2'b00));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL b2b cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
        checks++;
        if (retired !== 32'd2) begin
            errors++;
            $display("FAIL b2b_retired: got %0d want 2", retired);
        end
    endtask

    // SYSTEM halts. HALT is terminal: start pulses and write requests are ignored.
    task automatic test_halt();
        int n = 0;
        cyc_t c;
        do_reset();
        push(1, 1, 1, 1, 1, OP_SYS, ev(3'd0, F_NONE, 2'b00));
        push(0, 1, 1, 1, 1, OP_SYS, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 1, 1, 1, 1, OP_SYS, ev(3'd2, F_NONE, 2'b00));
        for (int i = 0; i < 20; i++)
            push(logic'(i % 2), 1, 1, 1, 1, OP_SYS, ev(3'd6, F_HALT, 2'b00));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL halt cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL halt_retired: got %0d want 0", retired);
        end
    endtask

    // One good instruction, then an illegal opcode traps with cause 01.
    task automatic test_illegal();
        int n = 0;
        cyc_t c;
        do_reset();
        push(1, 1, 1, 1, 0, OP_ALU, ev(3'd0, F_NONE, 2'b00));
        push(0, 1, 1, 1, 0, OP_ALU, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 1, 1, 1, 0, OP_ALU, ev(3'd2, F_NONE, 2'b00));
        push(0, 1, 1, 1, 0, OP_ALU, ev(3'd3, F_NONE, 2'b00));
        push(0, 1, 1, 1, 0, OP_ALU, ev(3'd5, F_WB_RF, 2'b00));
        push(0, 1, 1, 1, 1, OP_BAD, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 1, 1, 1, 1, OP_BAD, ev(3'd2, F_NONE, 2'b00));
        for (int i = 0; i < 5; i++)
            push(1, 1, 1, 1, 1, OP_BAD, ev(3'd7, F_TRAP, 2'b01));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL illegal cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
        checks++;
        if (retired !== 32'd1) begin
            errors++;
            $display("FAIL illegal_retired: got %0d want 1", retired);
        end
    endtask

    // Reset while a store waits in MEM: outputs clear at once, and the
    // controller stays quiet in IDLE afterwards despite active requests.
    task automatic test_reset_mid_mem();
        int n = 0;
        cyc_t c;
        do_reset();
        push(1, 1, 1, 1, 0, OP_ALU, ev(3'd0, F_NONE, 2'b00));
        push(0, 1, 1, 1, 0, OP_ALU, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 1, 1, 1, 0, OP_ALU, ev(3'd2, F_NONE, 2'b00));
        push(0, 1, 1, 1, 0, OP_ALU, ev(3'd3, F_NONE, 2'b00));
        push(0, 1, 0, 1, 0, OP_ALU, ev(3'd5, F_WB_RF, 2'b00));
        push(0, 1, 0, 1, 1, OP_STORE, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 1, 0, 1, 1, OP_STORE, ev(3'd2, F_NONE, 2'b00));
        push(0, 1, 0, 1, 1, OP_STORE, ev(3'd3, F_NONE, 2'b00));
        push(0, 1, 0, 1, 1, OP_STORE, ev(3'd4, F_MEM_WR, 2'b00));
        push(0, 1, 0, 1, 1, OP_STORE, ev(3'd4, F_MEM_WR, 2'b00));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL midmem cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
        #2; reset = 1'b1; #1;
        checks++;
        if (obs !== ev(3'd0, F_NONE, 2'b00) || retired !== 32'd0) begin
            errors++;
            $display("FAIL midmem_reset: got %h/%0d want %h/0", obs, retired, ev(3'd0, F_NONE, 2'b00));
        end
        @(posedge clock); #1; reset = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++)
            push(0, 1, 1, 1, 1, OP_STORE, ev(3'd0, F_NONE, 2'b00));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL postreset cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
    endtask

    // Long instruction-memory stall: with the watchdog it traps at the limit
    // unless ready arrives on the limit cycle; without it FETCH just waits.
    task automatic test_fetch_wait();
        int n = 0;
        cyc_t c;
        do_reset();
`ifdef MEM_TIMEOUT_EN
        push(1, 0, 0, 1, 0, OP_ALU, ev(3'd0, F_NONE, 2'b00));
        for (int i = 0; i < TIMEOUT; i++)
            push(0, 0, 0, 1, 0, OP_ALU, ev(3'd1, F_FETCH, 2'b00));
        for (int i = 0; i < 3; i++)
            push(0, 0, 0, 1, 0, OP_ALU, ev(3'd7, F_TRAP, 2'b10));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL timeout cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
        do_reset();
        n = 0;
        push(1, 0, 0, 1, 0, OP_ALU, ev(3'd0, F_NONE, 2'b00));
        for (int i = 0; i < TIMEOUT - 1; i++)
            push(0, 0, 0, 1, 0, OP_ALU, ev(3'd1, F_FETCH, 2'b00));
`else
        push(1, 0, 0, 1, 0, OP_ALU, ev(3'd0, F_NONE, 2'b00));
        for (int i = 0; i < 40; i++)
            push(0, 0, 0, 1, 0, OP_ALU, ev(3'd1, F_FETCH, 2'b00));
`endif
        push(0, 1, 0, 1, 0, OP_ALU, ev(3'd1, F_IRLOAD, 2'b00));
        push(0, 0, 0, 1, 0, OP_ALU, ev(3'd2, F_NONE, 2'b00));
        push(0, 0, 0, 1, 0, OP_ALU, ev(3'd3, F_NONE, 2'b00));
        push(0, 0, 0, 1, 0, OP_ALU, ev(3'd5, F_WB_RF, 2'b00));
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            dec_wEn = c.dec_wEn; dec_mem_wEn = c.dec_mem_wEn; opcode = c.opcode;
            @(negedge clock);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL fetchwait cycle %0d: got %h want %h", n, obs, c.exp);
            end
            @(posedge clock); #1; n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        dec_wEn = 1'b0; dec_mem_wEn = 1'b0; opcode = OP_ALU;
        test_reset();
        test_alu();
        test_load();
        test_store_wait();
        test_back_to_back();
        test_halt();
        test_illegal();
        test_reset_mid_mem();
        test_fetch_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
